// File: rtl/mux4x1_arbiter_pkg.sv
// Shared types and helpers for the 4-way rotating-priority mux arbiter.
package mux4x1_arbiter_pkg;

  localparam int unsigned NREQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // Rotating-priority search: first set bit of req starting at last+1, wrapping 3->0.
  function automatic pick_t rr_pick(input logic [NREQ-1:0] req, input logic [1:0] last);
    pick_t      r;
    logic [1:0] cand;
    r = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = last + 2'(k);
      if (!r.found && req[cand]) begin
        r.found = 1'b1;
        r.idx   = cand;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux4x1_arbiter_mux4x1.sv
// Plain 4:1 data mux selected by a 2-bit binary index.
module mux4x1 (
  input  logic [3:0] i,
  input  logic [1:0] sel,
  output logic       y
);

  // Pure combinational select of one data bit.
  always_comb begin
    y = i[sel];
  end

endmodule

// File: rtl/mux4x1_arbiter.sv
// 4-requester arbiter with rotating priority and a per-owner hold limit,
// steering a 4:1 data mux to the current owner.
module mux4x1_arbiter
  import mux4x1_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] i,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      sel,
  output logic            gnt_valid,
  output logic            y
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [3:0]      hold_cnt_q, hold_cnt_d;
  logic [1:0]      last_owner_q, last_owner_d;

  pick_t           win_all;
  pick_t           win_oth;
  logic            new_grant;
  logic [1:0]      new_idx;
  logic            mux_y;

  // State and output registers; synchronous reset leaves last_owner at 3 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      sel_q        <= '0;
      hold_cnt_q   <= '0;
      last_owner_q <= 2'd3;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      sel_q        <= sel_d;
      hold_cnt_q   <= hold_cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Next-state logic: pick a winner when idle, hand over on drop or hold expiry, otherwise count hold cycles.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    sel_d        = sel_q;
    hold_cnt_d   = hold_cnt_q;
    last_owner_d = last_owner_q;
    new_grant    = 1'b0;
    new_idx      = '0;

    win_all = rr_pick(req, last_owner_q);
    win_oth = rr_pick(req & ~gnt_q, last_owner_q);

    unique case (state_q)
      IDLE: begin
        if (win_all.found) begin
          new_grant = 1'b1;
          new_idx   = win_all.idx;
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          if (win_oth.found) begin
            new_grant = 1'b1;
            new_idx   = win_oth.idx;
          end else begin
            state_d    = IDLE;
            gnt_d      = '0;
            hold_cnt_d = '0;
          end
        end else if (hold_cnt_q == HOLD_LAST) begin
          if (win_oth.found) begin
            new_grant = 1'b1;
            new_idx   = win_oth.idx;
          end else begin
            hold_cnt_d = '0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    // Every path that hands out a fresh grant shares this update.
    if (new_grant) begin
      state_d          = GRANT;
      gnt_d            = '0;
      gnt_d[new_idx]   = 1'b1;
      sel_d            = new_idx;
      hold_cnt_d       = '0;
      last_owner_d     = new_idx;
    end
  end

  mux4x1 u_mux (
    .i   (i),
    .sel (sel_q),
    .y   (mux_y)
  );

  // Registered grant outputs; data output gated so it reads 0 with no owner.
  always_comb begin
    gnt       = gnt_q;
    sel       = sel_q;
    gnt_valid = (state_q == GRANT);
    y         = mux_y & gnt_valid;
  end

endmodule

// File: doc/mux4x1_arbiter.md
MUX4X1_ARBITER -- requirements
Module: mux4x1_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 4, giving the maximum consecutive grant cycles per owner while others wait; legal range 1..16.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port req, input, 4 bits: request per requester; bit k belongs to requester k.
REQ-005 SHALL have port i, input, 4 bits: data bit per requester; bit k belongs to requester k.
REQ-006 SHALL have port gnt, output, 4 bits: one-hot grant, registered.
REQ-007 SHALL have port sel, output, 2 bits: binary index of the current owner, registered; drives the mux select.
REQ-008 SHALL have port gnt_valid, output, 1 bit: high while any grant is active.
REQ-009 SHALL have port y, output, 1 bit: i[sel] when gnt_valid is high, else 0.

Function
REQ-010 SHALL implement a 2-state FSM with states IDLE (no owner) and GRANT (one owner).
REQ-011 SHALL keep gnt at zero or exactly one bit high, with gnt == (1 << sel) whenever gnt_valid is 1.
REQ-012 SHALL use rotating priority: the search starts at (last_owner+1) mod 4 and wraps 3->0; last_owner is updated on every new grant.
REQ-013 IDLE: if req != 0 in cycle N, SHALL assert gnt to the priority winner from cycle N+1 and enter GRANT; otherwise SHALL stay in IDLE.
REQ-014 GRANT: SHALL keep the owner while req[owner]=1, unless the hold limit is reached (REQ-016).
REQ-015 Owner drops req in cycle N: if any other req is high, SHALL grant the rotating winner in N+1 with no idle gap; otherwise SHALL enter IDLE in N+1 (gnt=0, gnt_valid=0).
REQ-016 Hold limit: hold_cnt SHALL clear to 0 on each new grant and increment each GRANT cycle. When hold_cnt==MAX_HOLD-1 and another requester is pending, SHALL rotate to the next winner in the following cycle.
REQ-017 Hold limit reached with no other requester pending: SHALL keep the owner and clear hold_cnt.
REQ-018 Requests arriving while the owner holds SHALL NOT preempt before the hold limit.
REQ-019 Several requests rising in the same cycle SHALL be resolved by rotating priority only.
REQ-020 MAX_HOLD=1 SHALL rotate every cycle while two or more requesters are active.
REQ-021 y SHALL be combinational from the registered sel and the current i (0 extra latency relative to sel).

Reset
REQ-022 While rst=1 at a clock edge: state=IDLE, gnt=4'b0000, sel=2'b00, gnt_valid=0, hold_cnt=0, last_owner=3; y therefore 0.
REQ-023 Reset asserted mid-grant SHALL drop the grant on the next edge regardless of req; first grant after reset goes to requester 0 if req[0]=1.

Structure
REQ-024 A shared package SHALL hold the FSM state encoding (IDLE=1'b0, GRANT=1'b1) and the requester count constant NREQ=4.
REQ-025 SHALL instantiate mux4x1 (ports i, sel, y) as the only sub-module for the data path; y SHALL be gated by gnt_valid at the top level.
REQ-026 The priority search SHALL be written as a function or a combinational block; no second FSM.

Verification
REQ-027 Reset then req=0001, i=0001 -> gnt=0001, sel=00, y=1 one cycle after req; gnt=0000 one cycle after req drops.
REQ-028 req=1111 held, MAX_HOLD=4 -> owner sequence 0,1,2,3,0, each held exactly 4 cycles; handovers with no gnt=0 cycle.
REQ-029 Owner 2 drops req while req=1001 -> next gnt=1000 (3 follows 2), then 0001 after the hold limit or when req[3] drops.
REQ-030 Single requester req=0100 held 20 cycles -> gnt=0100 continuously, no dropouts when the hold counter wraps.
REQ-031 rst pulsed for 1 cycle while gnt=0010 and req=1111 -> all outputs zero next edge; first grant after release = 0001.
REQ-032 Every cycle, checker asserts gnt is one-hot or zero, gnt==(1<<sel) when valid, and y==i[sel]&gnt_valid.
